// File: rtl/mult_div_unit.sv
`default_nettype none
// ============================================================================
// mult_div_unit : iterative MIPS MULT/MULTU/DIV/DIVU unit owning HI/LO.
// Optional feature macro MDU_ABORT_EN adds i_abort to cancel an operation.
// Revision 1.0
// ============================================================================
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_rs,
    input  logic [WIDTH-1:0] i_rt,
    input  logic             i_mthi,
    input  logic             i_mtlo,
    input  logic             i_sel_hi,
`ifdef MDU_ABORT_EN
    input  logic             i_abort,
`endif
    output logic             o_busy,
    output logic             o_done,
    output logic             o_div_zero,
    output logic [WIDTH-1:0] o_hilo_data
);

    localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic [WIDTH-1:0] acc_hi;
    logic [WIDTH-1:0] acc_lo;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] rs_lat;
    logic [CW-1:0]    cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dz;
    logic             is_div;
    logic             busy;
    logic             done;
    logic             div_zero;

    logic             abort_req;
`ifdef MDU_ABORT_EN
    assign abort_req = i_abort;
`else
    assign abort_req = 1'b0;
`endif

    // MULT and DIV (op[0]==0) run on magnitudes and fix the sign afterwards
    logic             op_signed;
    logic [WIDTH-1:0] rs_mag;
    logic [WIDTH-1:0] rt_mag;
    assign op_signed = ~i_op[0];
    assign rs_mag    = (op_signed && i_rs[WIDTH-1]) ? -i_rs : i_rs;
    assign rt_mag    = (op_signed && i_rt[WIDTH-1]) ? -i_rt : i_rt;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] product;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opb} : '0);
    assign div_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign div_diff  = div_shift - {1'b0, opb};
    assign product   = {acc_hi, acc_lo};
    assign prod_fix  = neg_q ? -product : product;
    // A zero divisor leaves the all-ones quotient and echoes the dividend
    assign quo_fix   = dz ? '1 : (neg_q ? -acc_lo : acc_lo);
    assign rem_fix   = dz ? rs_lat : (neg_r ? -acc_hi : acc_hi);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state    <= IDLE;
            hi       <= '0;
            lo       <= '0;
            acc_hi   <= '0;
            acc_lo   <= '0;
            opb      <= '0;
            rs_lat   <= '0;
            cnt      <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            dz       <= 1'b0;
            is_div   <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            done     <= 1'b0;
            div_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (i_start && !abort_req) begin
                        state  <= i_op[1] ? DIV : MUL;
                        acc_hi <= '0;
                        acc_lo <= i_op[1] ? rs_mag : rt_mag;
                        opb    <= i_op[1] ? rt_mag : rs_mag;
                        rs_lat <= i_rs;
                        neg_q  <= op_signed & (i_rs[WIDTH-1] ^ i_rt[WIDTH-1]);
                        neg_r  <= op_signed & i_rs[WIDTH-1];
                        dz     <= i_op[1] & (i_rt == '0);
                        is_div <= i_op[1];
                        cnt    <= '0;
                        busy   <= 1'b1;
                    end else if (!i_start) begin
                        if (i_mthi) hi <= i_rs;
                        if (i_mtlo) lo <= i_rs;
                    end
                end
                MUL, DIV: begin
                    if (abort_req) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        if (state == MUL) begin
                            acc_hi <= mul_sum[WIDTH:1];
                            acc_lo <= {mul_sum[0], acc_lo[WIDTH-1:1]};
                        end else if (!div_diff[WIDTH]) begin
                            acc_hi <= div_diff[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b1};
                        end else begin
                            acc_hi <= div_shift[WIDTH-1:0];
                            acc_lo <= {acc_lo[WIDTH-2:0], 1'b0};
                        end
                        if (cnt == LAST) begin
                            state    <= FIX;
                            done     <= 1'b1;
                            div_zero <= dz;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                FIX: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (!abort_req) begin
                        if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // An abort raised during FIX also suppresses the completion pulses
    assign o_busy      = busy;
    assign o_done      = done & ~abort_req;
    assign o_div_zero  = div_zero & ~abort_req;
    assign o_hilo_data = i_sel_hi ? hi : lo;

endmodule
`default_nettype wire
